// File: rtl/ch376_io_decoder.sv
// MSX I/O decoder for the CH376: a zero-latency chip select and BUSDIR for the bus,
// plus synchronised, edge-detected access pulses and a latched port select for local logic.
module ch376_io_decoder #(
   parameter logic [7:0] BASE_ADDR   = 8'h10,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] address,
   input  logic       iorq_n,
   input  logic       rd_n,
   input  logic       wr_n,
   output logic       cs,
   output logic       busdir,
   output logic       port_sel,
   output logic       rd_pulse,
   output logic       wr_pulse
);

   localparam logic [6:0] BASE_HI = BASE_ADDR[7:1];

   logic match;
   logic rd_acc;
   logic wr_acc;

   logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d;
   logic [SYNC_STAGES-1:0] wr_sync_q, wr_sync_d;
   logic [SYNC_STAGES-1:0] a0_sync_q, a0_sync_d;
   logic                   rd_hist_q, rd_hist_d;
   logic                   wr_hist_q, wr_hist_d;
   logic                   rd_pulse_q, rd_pulse_d;
   logic                   wr_pulse_q, wr_pulse_d;
   logic                   port_sel_q, port_sel_d;
   logic                   rd_rise;
   logic                   wr_rise;

   // Bus-facing outputs stay purely combinational so the MSX slot sees no clock latency.
   always_comb begin
      match  = (address[7:1] == BASE_HI);
      rd_acc = match & ~iorq_n & ~rd_n;
      wr_acc = match & ~iorq_n & ~wr_n;
      cs     = ~(match & ~iorq_n);
      busdir = ~rd_acc;
   end

   always_comb begin
      rd_sync_d  = {rd_sync_q[SYNC_STAGES-2:0], rd_acc};
      wr_sync_d  = {wr_sync_q[SYNC_STAGES-2:0], wr_acc};
      a0_sync_d  = {a0_sync_q[SYNC_STAGES-2:0], address[0]};
      rd_hist_d  = rd_sync_q[SYNC_STAGES-1];
      wr_hist_d  = wr_sync_q[SYNC_STAGES-1];
      rd_rise    = rd_sync_q[SYNC_STAGES-1] & ~rd_hist_q;
      wr_rise    = wr_sync_q[SYNC_STAGES-1] & ~wr_hist_q;
      rd_pulse_d = rd_rise;
      wr_pulse_d = wr_rise;
      // A0 travels through its own chain so it is aligned with the access that caused the pulse.
      port_sel_d = (rd_rise | wr_rise) ? a0_sync_q[SYNC_STAGES-1] : port_sel_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_sync_q  <= '0;
         wr_sync_q  <= '0;
         a0_sync_q  <= '0;
         rd_hist_q  <= 1'b0;
         wr_hist_q  <= 1'b0;
         rd_pulse_q <= 1'b0;
         wr_pulse_q <= 1'b0;
         port_sel_q <= 1'b0;
      end else begin
         rd_sync_q  <= rd_sync_d;
         wr_sync_q  <= wr_sync_d;
         a0_sync_q  <= a0_sync_d;
         rd_hist_q  <= rd_hist_d;
         wr_hist_q  <= wr_hist_d;
         rd_pulse_q <= rd_pulse_d;
         wr_pulse_q <= wr_pulse_d;
         port_sel_q <= port_sel_d;
      end
   end

   assign rd_pulse = rd_pulse_q;
   assign wr_pulse = wr_pulse_q;
   assign port_sel = port_sel_q;

endmodule

// File: tb/tb_ch376_io_decoder.sv
// Directed bench for ch376_io_decoder: combinational decode sweeps, pulse timing,
// port select latching, asynchronous reset and a relocated base address.
module tb_ch376_io_decoder;

   logic       clk;
   logic       rst_n;
   logic [7:0] address;
   logic       iorq_n;
   logic       rd_n;
   logic       wr_n;
   logic       cs, busdir, port_sel, rd_pulse, wr_pulse;
   logic       cs2, busdir2, port_sel2, rd_pulse2, wr_pulse2;

   int total = 0;
   int bad   = 0;
   int rd_cnt = 0;
   int wr_cnt = 0;

   ch376_io_decoder #(.BASE_ADDR(8'h10), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .address(address), .iorq_n(iorq_n),
      .rd_n(rd_n), .wr_n(wr_n), .cs(cs), .busdir(busdir),
      .port_sel(port_sel), .rd_pulse(rd_pulse), .wr_pulse(wr_pulse)
   );

   ch376_io_decoder #(.BASE_ADDR(8'h20), .SYNC_STAGES(2)) dut_hi (
      .clk(clk), .rst_n(rst_n), .address(address), .iorq_n(iorq_n),
      .rd_n(rd_n), .wr_n(wr_n), .cs(cs2), .busdir(busdir2),
      .port_sel(port_sel2), .rd_pulse(rd_pulse2), .wr_pulse(wr_pulse2)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulses are one clock wide, so one sample per cycle counts each exactly once.
   always @(negedge clk) begin
      if (rd_pulse) rd_cnt <= rd_cnt + 1;
      if (wr_pulse) wr_cnt <= wr_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [7:0] a, input logic io, input logic r, input logic w);
      @(negedge clk);
      address = a;
      iorq_n  = io;
      rd_n    = r;
      wr_n    = w;
      #1;
   endtask

   task automatic idle(input int n);
      drive(8'h00, 1'b1, 1'b1, 1'b1);
      repeat (n) @(negedge clk);
   endtask

   // Sweep {iorq_n,rd_n} = 00,01,10,11, holding each phase 6 clocks.
   task automatic sweep(input logic [7:0] a, input logic [3:0] cs_tab, input logic [3:0] bd_tab,
                        input string tag);
      logic [1:0] v;
      for (int i = 0; i < 4; i++) begin
         v = i[1:0];
         drive(a, v[1], v[0], 1'b1);
         check({tag, "_cs"}, cs, cs_tab[i]);
         check({tag, "_busdir"}, busdir, bd_tab[i]);
         repeat (6) @(negedge clk);
      end
   endtask

   initial begin
      int rd0, wr0;
      logic [3:0] no_dec_cs, no_dec_bd, dec_cs, dec_bd;
      no_dec_cs = 4'b1111;
      no_dec_bd = 4'b1111;
      dec_cs    = 4'b1100;  // index 0:00->0, 1:01->0, 2:10->1, 3:11->1
      dec_bd    = 4'b1110;  // only 00 reads
      address = 8'h00; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
      rst_n = 1'b0;
      #1;
      check("rst_cs_match", cs, 1'b1);
      address = 8'h10; iorq_n = 1'b0; rd_n = 1'b0;
      #1;
      check("rst_cs_comb", cs, 1'b0);
      check("rst_busdir_comb", busdir, 1'b0);
      check("rst_rd_pulse", rd_pulse, 1'b0);
      check("rst_wr_pulse", wr_pulse, 1'b0);
      check("rst_port_sel", port_sel, 1'b0);
      address = 8'h00; iorq_n = 1'b1; rd_n = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // non-matching address
      rd0 = rd_cnt; wr0 = wr_cnt;
      sweep(8'h12, no_dec_cs, no_dec_bd, "a12");
      check("a12_rd_pulses", rd_cnt - rd0, 0);
      check("a12_wr_pulses", wr_cnt - wr0, 0);

      // data port, read phase held
      rd0 = rd_cnt;
      sweep(8'h10, dec_cs, dec_bd, "a10");
      check("a10_rd_pulses", rd_cnt - rd0, 1);
      check("a10_port_sel", port_sel, 1'b0);
      idle(4);

      // command port
      rd0 = rd_cnt;
      sweep(8'h11, dec_cs, dec_bd, "a11");
      check("a11_rd_pulses", rd_cnt - rd0, 1);
      check("a11_port_sel", port_sel, 1'b1);
      idle(4);

      // write held 10 clocks: single pulse on edge 3
      wr0 = wr_cnt; rd0 = rd_cnt;
      drive(8'h10, 1'b0, 1'b1, 1'b0);
      check("wr_cs", cs, 1'b0);
      check("wr_busdir", busdir, 1'b1);
      for (int e = 1; e <= 10; e++) begin
         @(posedge clk);
         #1;
         check($sformatf("wr_pulse_e%0d", e), wr_pulse, (e == 3) ? 1'b1 : 1'b0);
         if (e == 3) check("wr_port_sel", port_sel, 1'b0);
      end
      @(negedge clk);
      check("wr_pulse_count", wr_cnt - wr0, 1);
      check("wr_no_rd_pulse", rd_cnt - rd0, 0);
      idle(4);

      // reset in the middle of a read pulse
      drive(8'h11, 1'b0, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      #2;
      check("mid_rd_pulse", rd_pulse, 1'b1);
      check("mid_port_sel", port_sel, 1'b1);
      rst_n = 1'b0;
      #1;
      check("async_rd_pulse", rd_pulse, 1'b0);
      check("async_port_sel", port_sel, 1'b0);
      check("async_cs", cs, 1'b0);
      check("async_busdir", busdir, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         @(posedge clk);
         #1;
         check($sformatf("rel_rd_pulse_e%0d", e), rd_pulse, (e == 3) ? 1'b1 : 1'b0);
      end
      check("rel_port_sel", port_sel, 1'b1);
      idle(4);

      // relocated base
      drive(8'h20, 1'b0, 1'b1, 1'b1);
      check("hi_20_cs", cs2, 1'b0);
      check("lo_20_cs", cs, 1'b1);
      drive(8'h21, 1'b0, 1'b1, 1'b1);
      check("hi_21_cs", cs2, 1'b0);
      drive(8'h21, 1'b0, 1'b0, 1'b1);
      check("hi_21_busdir", busdir2, 1'b0);
      drive(8'h10, 1'b0, 1'b1, 1'b1);
      check("hi_10_cs", cs2, 1'b1);
      check("lo_10_cs", cs, 1'b0);
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
